case_2_sdiv_11s_8s_11_seq_1: RTL

CASE_2_SDIV_11S_8S_11_SEQ_1 -- requirements
Module: case_2_sdiv_11s_8s_11_seq_1

---
 rtl/case_2_div_pkg.sv | 19 +
 rtl/case_2_sdiv_11s_8s_11_seq_1_step.sv | 44 ++++
 rtl/case_2_sdiv_11s_8s_11_seq_1.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/case_2_div_pkg.sv
// -----------------------------------------------------------------------------
// case_2_div_pkg
//   Shared definitions for the sequential signed divider family:
//   operand/result widths, the number of restoring iterations and the
//   controller state encoding.
// -----------------------------------------------------------------------------
package case_2_div_pkg;

    localparam int DIN0_W     = 11;  // dividend width
    localparam int DIN1_W     = 8;   // divisor width
    localparam int DOUT_W     = 11;  // quotient / remainder width
    localparam int ITERATIONS = 11;  // one quotient bit per dividend bit

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

endpackage : case_2_div_pkg

// File: rtl/case_2_sdiv_11s_8s_11_seq_1_step.sv
// -----------------------------------------------------------------------------
// case_2_sdiv_11s_8s_11_seq_1_step
//   One radix-2 restoring division iteration on unsigned magnitudes.
//   The partial remainder is shifted left by one, taking in the next dividend
//   bit; the divisor is trial-subtracted and the difference is kept only when
//   it does not go negative. The dividend register doubles as the quotient
//   register: each step shifts one dividend bit out of the top and one
//   quotient bit in at the bottom.
//
//   Ports
//     rem_in   partial remainder before this step
//     quo_in   dividend/quotient shift register before this step
//     divisor  divisor magnitude
//     rem_out  partial remainder after this step
//     quo_out  dividend/quotient shift register after this step
// -----------------------------------------------------------------------------
module case_2_sdiv_11s_8s_11_seq_1_step #(
    parameter int DVD_W = 11,
    parameter int DVS_W = 8
) (
    input  logic [DVD_W-1:0] rem_in,
    input  logic [DVD_W-1:0] quo_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] rem_out,
    output logic [DVD_W-1:0] quo_out
);

    logic [DVD_W:0]   shifted;
    logic [DVD_W:0]   dvs_ext;
    logic [DVD_W-1:0] trial;
    logic             fits;

    assign shifted = {rem_in, quo_in[DVD_W-1]};
    assign dvs_ext = {{(DVD_W + 1 - DVS_W){1'b0}}, divisor};
    assign fits    = (shifted >= dvs_ext);

    // When the subtraction is kept the true difference is below the divisor
    // (or, for a zero divisor, below 2**DVD_W), so the top bit can be dropped.
    assign trial   = shifted[DVD_W-1:0] - dvs_ext[DVD_W-1:0];

    assign rem_out = fits ? trial : shifted[DVD_W-1:0];
    assign quo_out = {quo_in[DVD_W-2:0], fits};

endmodule : case_2_sdiv_11s_8s_11_seq_1_step

// File: rtl/case_2_sdiv_11s_8s_11_seq_1.sv
// -----------------------------------------------------------------------------
// case_2_sdiv_11s_8s_11_seq_1
//   Sequential signed divider, 11-bit dividend by 8-bit divisor.
//   Operands are converted to magnitudes when start is accepted, divided by
//   ITERATIONS restoring steps (one per enabled clock), and the signed result
//   is registered on the following enabled edge together with a done strobe.
//   Quotient truncates toward zero; remainder takes the dividend's sign.
//   Division by zero yields quotient -1 and remainder = dividend;
//   -1024 / -1 wraps to -1024.
//
//   Ports
//     ap_clk    clock, rising edge
//     ap_rst_n  asynchronous active-low reset
//     ce        clock enable; low freezes every register
//     start     request, accepted when idle (or on the finishing edge)
//     din0      signed dividend
//     din1      signed divisor
//     busy      division in progress
//     done      one-cycle result strobe (held while ce is low)
//     dout      signed quotient, held between done pulses
//     remd      signed remainder, held between done pulses
//
//   Build option
//     CASE_2_SDIV_REM_EN  defined   -> remd carries the signed remainder
//                         undefined -> remd is tied to zero
// -----------------------------------------------------------------------------
module case_2_sdiv_11s_8s_11_seq_1
    import case_2_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] remd
);

    localparam int              CNT_W    = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [din0_WIDTH-1:0]   quo_q;
    logic [din0_WIDTH-1:0]   rem_q;
    logic [din1_WIDTH-1:0]   dvs_q;
    logic                    neg_quo_q;
    logic                    dvs_zero_q;
    logic [din0_WIDTH-1:0]   quo_step;
    logic [din0_WIDTH-1:0]   rem_step;
    logic [din0_WIDTH-1:0]   din0_mag;
    logic [din1_WIDTH-1:0]   din1_mag;
    logic [dout_WIDTH-1:0]   quo_final;
    logic                    iter_last;
    logic                    finish;
    logic                    accept;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    assign busy      = (state == S_CALC);
    assign iter_last = (cnt == LAST_CNT);
    assign finish    = busy && iter_last;
    // The finishing edge is also the first edge at which a new request is
    // taken, so back-to-back operations run with no idle cycle in between.
    assign accept    = start && (!busy || iter_last);

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)               state_nxt = S_CALC;
            S_CALC:  if (iter_last && !start) state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Operand conditioning
    // -------------------------------------------------------------------------
    // Two's-complement negation; the most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    assign din0_mag = din0[din0_WIDTH-1] ? ('0 - din0) : din0;
    assign din1_mag = din1[din1_WIDTH-1] ? ('0 - din1) : din1;

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    case_2_sdiv_11s_8s_11_seq_1_step #(
        .DVD_W (din0_WIDTH),
        .DVS_W (din1_WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // NOTE: the datapath registers are reset as well; they are few and a
    // defined post-reset value keeps them from propagating X in simulation.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt        <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                cnt        <= '0;
                quo_q      <= din0_mag;
                rem_q      <= '0;
                dvs_q      <= din1_mag;
                neg_quo_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                dvs_zero_q <= (din1 == '0);
            end else if (busy && !iter_last) begin
                cnt   <= cnt + CNT_W'(1);
                quo_q <= quo_step;
                rem_q <= rem_step;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result registers
    // -------------------------------------------------------------------------
    // A zero divisor leaves an all-ones quotient magnitude; the result is
    // forced to -1 so it does not depend on the operand signs.
    assign quo_final = dvs_zero_q ? '1
                     : dout_WIDTH'(neg_quo_q ? ('0 - quo_q) : quo_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done <= 1'b0;
            dout <= '0;
        end else if (ce) begin
            done <= finish;
            if (finish) begin
                dout <= quo_final;
            end
        end
    end

`ifdef CASE_2_SDIV_REM_EN
    logic                  neg_dvd_q;
    logic [dout_WIDTH-1:0] rem_final;

    // The remainder follows the dividend's sign only.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            neg_dvd_q <= 1'b0;
        end else if (ce && accept) begin
            neg_dvd_q <= din0[din0_WIDTH-1];
        end
    end

    assign rem_final = dout_WIDTH'(neg_dvd_q ? ('0 - rem_q) : rem_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            remd <= '0;
        end else if (ce && finish) begin
            remd <= rem_final;
        end
    end
`else
    assign remd = '0;
`endif

endmodule : case_2_sdiv_11s_8s_11_seq_1
